// File: rtl/cpu_axi_pkg.sv
// Shared types and helpers for the CPU-to-AXI bridge.
// Holds the bridge FSM states, access-size codes and strobe generation.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_B
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [3:0] gen_wstrb(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] s;
    case (size)
      SIZE_B:  s = 4'b0001 << addr;
      SIZE_H:  s = 4'b0011 << addr;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Merges the core's instruction and data SRAM-like ports onto one
// single-beat AXI master with data priority and one transfer in flight.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state;
  state_t      state_nx;
  logic        own_data;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        aw_done;
  logic        w_done;
  logic        inst_ok_q;
  logic        data_ok_q;
  logic        idle;
  logic        aw_hs;
  logic        w_hs;
  logic        r_hs;
  logic        b_hs;

  // Gating with resetn keeps a request from being acknowledged
  // in a cycle where the acceptance would be discarded.
  assign idle = (state == S_IDLE) & resetn;

  assign data_addr_ok = idle & data_req;
  assign inst_addr_ok = idle & inst_req & ~data_req;

  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);
  assign awvalid = (state == S_AW) & ~aw_done;
  assign wvalid  = (state == S_AW) & ~w_done;
  assign bready  = (state == S_B);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rready & rvalid;
  assign b_hs  = bready & bvalid;

  assign araddr       = addr_q;
  assign awaddr       = addr_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign inst_rdata   = rdata_q;
  assign data_rdata   = rdata_q;
  assign inst_data_ok = inst_ok_q;
  assign data_data_ok = data_ok_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (data_addr_ok)
          state_nx = data_wr ? S_AW : S_AR;
        else if (inst_addr_ok)
          state_nx = S_AR;
      end
      S_AR: if (arready) state_nx = S_R;
      S_R:  if (rvalid)  state_nx = S_IDLE;
      S_AW: begin
        if ((aw_done | aw_hs) & (w_done | w_hs))
          state_nx = S_B;
      end
      S_B:  if (bvalid)  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      own_data  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state     <= state_nx;
      inst_ok_q <= ~own_data & (r_hs | b_hs);
      data_ok_q <= own_data & (r_hs | b_hs);
      if (data_addr_ok) begin
        own_data <= 1'b1;
        addr_q   <= data_addr;
        wdata_q  <= data_wdata;
        wstrb_q  <= data_wr ? gen_wstrb(data_size, data_addr[1:0])
                            : 4'b0000;
      end else if (inst_addr_ok) begin
        own_data <= 1'b0;
        addr_q   <= inst_addr;
        wdata_q  <= '0;
        wstrb_q  <= 4'b0000;
      end
      if (state == S_AW) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (r_hs)
        rdata_q <= rdata;
    end
  end

endmodule
